// File: rtl/oddeven_seq_sorter.sv
// Sequential odd-even transposition sorter: one register bank, one phase per
// cycle, valid/ready on both sides, per-vector direction and optional early exit.
module oddeven_seq_sorter #(
  parameter int unsigned W          = 8,
  parameter int unsigned N          = 16,
  parameter bit          SIGNED     = 1'b0,
  parameter bit          EARLY_EXIT = 1'b1,
  parameter int unsigned CW         = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N*W-1:0]  in_data,
  input  logic            in_desc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [CW-1:0]   out_cycles
);

  localparam int unsigned PW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

  state_t         state;
  logic [W-1:0]   bank     [N];
  logic [W-1:0]   bank_nxt [N];
  logic [PW-1:0]  p;
  logic [PW-1:0]  p_inc;
  logic           desc_q;
  logic           prev_clean;
  logic           phase_swap;
  logic           sort_last;
  logic [CW-1:0]  cycles_nxt;

  function automatic logic word_gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    out_data = '0;
    for (int k = 0; k < int'(N); k++) out_data[k*W +: W] = bank[k];
  end

  // One compare-exchange phase; pairs start at index p[0] and never overlap.
  always_comb begin
    bank_nxt   = bank;
    phase_swap = 1'b0;
    for (int j = 0; j < int'(N) - 1; j++) begin
      if (1'(j) == p[0]) begin
        if (desc_q ? word_gt(bank[j+1], bank[j]) : word_gt(bank[j], bank[j+1])) begin
          bank_nxt[j]   = bank[j+1];
          bank_nxt[j+1] = bank[j];
          phase_swap    = 1'b1;
        end
      end
    end
  end

  assign p_inc      = p + PW'(1);
  assign sort_last  = (N == 1) || (p_inc == PW'(N)) ||
                      (EARLY_EXIT && !phase_swap && prev_clean);
  // A single word has nothing to compare, so it reports zero phases.
  assign cycles_nxt = (N == 1) ? '0 : CW'(p_inc);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      p          <= '0;
      desc_q     <= 1'b0;
      prev_clean <= 1'b0;
      out_cycles <= '0;
      for (int k = 0; k < int'(N); k++) bank[k] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < int'(N); k++) bank[k] <= in_data[k*W +: W];
            desc_q     <= in_desc;
            p          <= '0;
            prev_clean <= 1'b0;
            out_cycles <= '0;
            state      <= SORT;
          end
        end
        SORT: begin
          bank       <= bank_nxt;
          p          <= p_inc;
          prev_clean <= !phase_swap;
          if (sort_last) begin
            out_cycles <= cycles_nxt;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
